// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 multiplier among NUM_REQ requesters.
// Define FP32_MUL_ARB_STATS_EN to add the grant_cnt/idle_cnt statistics outputs.
module fp32_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    output logic                    mul_in_valid,
    input  logic [31:0]             mul_out_data,
    input  logic                    mul_out_valid,
    output logic                    err
`ifdef FP32_MUL_ARB_STATS_EN
    ,
    output logic [32*NUM_REQ-1:0]   grant_cnt,
    output logic [31:0]             idle_cnt
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DRN_W = $clog2(MUL_LATENCY + 2);
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(MUL_LATENCY + 1);

    logic [31:0]      a_arr [NUM_REQ];
    logic [31:0]      b_arr [NUM_REQ];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] issue_idx;
    logic             grant_any;

    logic [MUL_LATENCY-1:0] tag_vld;
    logic [IDX_W-1:0]       tag_idx [MUL_LATENCY];
    logic [DRN_W-1:0]       drain;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[32*i +: 32];
        assign b_arr[i] = req_b[32*i +: 32];
    end

    // First valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (!rst_n) begin
            grant_any = 1'b0;
        end
    end

    assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_in_valid <= 1'b0;
            issue_idx    <= '0;
        end else begin
            mul_in_valid <= grant_any;
            if (grant_any) begin
                rr_ptr    <= IDX_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
                mul_a     <= a_arr[grant_idx];
                mul_b     <= b_arr[grant_idx];
                issue_idx <= grant_idx;
            end
        end
    end

    // Tag pipe runs in lockstep with the multiplier; its last stage lines up with mul_out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            tag_vld[0] <= mul_in_valid;
            tag_idx[0] <= issue_idx;
            for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    // The multiplier is not reset here, so results already in flight are ignored until drain hits 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
            drain     <= DRAIN_INIT;
        end else begin
            rsp_valid <= tag_vld[MUL_LATENCY-1] ? (NUM_REQ'(1) << tag_idx[MUL_LATENCY-1]) : '0;
            if (tag_vld[MUL_LATENCY-1]) begin
                rsp_data <= mul_out_data;
            end
            if (drain != '0) begin
                drain <= drain - 1'b1;
            end else if (mul_out_valid != tag_vld[MUL_LATENCY-1]) begin
                err <= 1'b1;
            end
        end
    end

`ifdef FP32_MUL_ARB_STATS_EN
    logic [31:0] gcnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                gcnt[k] <= '0;
            end
            idle_cnt <= '0;
        end else begin
            if (grant_any) begin
                gcnt[grant_idx] <= gcnt[grant_idx] + 32'd1;
            end
            if (!mul_in_valid) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        assign grant_cnt[32*i +: 32] = gcnt[i];
    end
`endif

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Self-checking bench for fp32_mul_arbiter: directed vectors, routing/reset/mismatch sequences and
// random traffic checked against a timestamped response scoreboard and a bench multiplier model.
module tb_fp32_mul_arbiter;

    localparam int N = 4;
    localparam int L = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_a;
    logic [32*N-1:0]  req_b;
    logic [N-1:0]     rsp_valid;
    logic [31:0]      rsp_data;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_in_valid;
    logic [31:0]      mul_out_data;
    logic             mul_out_valid;
    logic             err;
`ifdef FP32_MUL_ARB_STATS_EN
    logic [32*N-1:0]  grant_cnt;
    logic [31:0]      idle_cnt;
`endif

    fp32_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
        .mul_out_data(mul_out_data), .mul_out_valid(mul_out_valid),
        .err(err)
`ifdef FP32_MUL_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .idle_cnt(idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Truncating FP32 multiply for normal operands; specials map to a deterministic stand-in.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || ea == 255 || eb == 0 || eb == 255) return a ^ b;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    // Bench multiplier: fixed L-cycle pipeline, deliberately never reset.
    logic [L-1:0] m_vld = '0;
    logic [31:0]  m_dat [L];
    logic         inject = 1'b0;

    always @(posedge clk) begin
        m_vld    <= {m_vld[L-2:0], mul_in_valid};
        m_dat[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < L; i++) m_dat[i] <= m_dat[i-1];
    end

    assign mul_out_valid = m_vld[L-1] | inject;
    assign mul_out_data  = m_dat[L-1];

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] ready;
    } vec_t;

    rsp_t        exp_q[$];
    int          cyc, mptr, rel_cnt, idle_exp, checks, errors;
    int          gnt_exp [N];
    logic        exp_miv, exp_err;
    logic [31:0] exp_ma, exp_mb, exp_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mptr = 0; rel_cnt = 0; idle_exp = 0;
        exp_miv = 1'b0; exp_err = 1'b0;
        exp_ma = '0; exp_mb = '0; exp_rdata = '0;
        for (int i = 0; i < N; i++) gnt_exp[i] = 0;
    endtask

    task automatic set_rst(input logic v);
        #1 rst_n = v;
        if (!v) model_reset();
    endtask

    function automatic logic [32*N-1:0] rnd_ops();
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: check this cycle's outputs, drive requests, check grant, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] a, input logic [32*N-1:0] b,
                        output logic [N-1:0] rdy);
        logic [N-1:0] exp_rv, exp_rdy;
        int           g;
        logic         mv_now;
        rsp_t         r;
        @(negedge clk);
        exp_rv = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            exp_rv[r.idx] = 1'b1;
            exp_rdata = r.data;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("rsp_data", rsp_data, exp_rdata);
        chk("mul_in_valid", 32'(mul_in_valid), 32'(exp_miv));
        chk("mul_a", mul_a, exp_ma);
        chk("mul_b", mul_b, exp_mb);
        chk("err", 32'(err), 32'(exp_err));
        mv_now = m_vld[L-1];
        req_valid = v;
        req_a = a;
        req_b = b;
        #1;
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst_n) begin
            if (!exp_miv) idle_exp++;
            if (inject && !mv_now && rel_cnt >= L + 1) exp_err = 1'b1;
            if (g >= 0) begin
                r.idx  = g;
                r.data = fmul(a[32*g +: 32], b[32*g +: 32]);
                r.due  = cyc + L + 2;
                exp_q.push_back(r);
                mptr    = (g + 1) % N;
                exp_ma  = a[32*g +: 32];
                exp_mb  = b[32*g +: 32];
                exp_miv = 1'b1;
                gnt_exp[g]++;
            end else begin
                exp_miv = 1'b0;
            end
            rel_cnt++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] rdy;
        for (int i = 0; i < n; i++) step('0, rnd_ops(), rnd_ops(), rdy);
    endtask

    vec_t tbl [23];

    initial begin
        logic [N-1:0]    rdy;
        logic [32*N-1:0] a, b;

        for (int i = 0; i < 12; i++) tbl[i] = '{4'b1111, 4'(1 << (i % 4))};
        tbl[12] = '{4'b0001, 4'b0001};
        tbl[13] = '{4'b1000, 4'b1000};
        for (int i = 14; i < 18; i++) tbl[i] = '{4'b0000, 4'b0000};
        tbl[18] = '{4'b1000, 4'b1000};
        tbl[19] = '{4'b1111, 4'b0001};
        tbl[20] = '{4'b0101, 4'b0100};
        tbl[21] = '{4'b0011, 4'b0001};
        tbl[22] = '{4'b0000, 4'b0000};

        checks = 0; errors = 0; cyc = 0;
        req_valid = '0; req_a = '0; req_b = '0;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset state, with all requesters asserting valid
        repeat (3) step(4'b1111, rnd_ops(), rnd_ops(), rdy);
        set_rst(1'b1);
        idle(L + 3);

        // Single issue from requester 2
        a = '0; b = '0;
        a[64 +: 32] = 32'h40400000;
        b[64 +: 32] = 32'h40000000;
        step(4'b0100, a, b, rdy);
        idle(9);
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("single_rsp_data", rsp_data, 32'h40C00000);
        chk("single_err", 32'(err), 32'h0);

        // Back-to-back routing to requesters 1 and 3
        a = '0; b = '0;
        a[32 +: 32] = 32'h3FC00000;
        b[32 +: 32] = 32'h3FC00000;
        step(4'b0010, a, b, rdy);
        a = '0; b = '0;
        a[96 +: 32] = 32'h40000000;
        b[96 +: 32] = 32'h40000000;
        step(4'b1000, a, b, rdy);
        idle(8);
        #1;
        chk("route1_valid", 32'(rsp_valid), 32'h2);
        chk("route1_data", rsp_data, 32'h40100000);
        idle(1);
        #1;
        chk("route3_valid", 32'(rsp_valid), 32'h8);
        chk("route3_data", rsp_data, 32'h40800000);

        // Fairness and sparse-request vectors
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].valid, rnd_ops(), rnd_ops(), rdy);
            chk("tbl_ready", 32'(rdy), 32'(tbl[i].ready));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) step(N'($urandom), rnd_ops(), rnd_ops(), rdy);
        idle(L + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        // Reset with four operations in flight
        repeat (4) step(4'b1111, rnd_ops(), rnd_ops(), rdy);
        idle(3);
        set_rst(1'b0);
        idle(2);
        set_rst(1'b1);
        idle(L + 4);
        step(4'b0010, rnd_ops(), rnd_ops(), rdy);
        idle(L + 3);
        chk("reset_queue_drained", 32'(exp_q.size()), 32'h0);

        // Spurious multiplier result after drain
        #1 inject = 1'b1;
        step('0, rnd_ops(), rnd_ops(), rdy);
        #1 inject = 1'b0;
        chk("err_set", 32'(err), 32'h1);
        idle(5);
        chk("err_sticky", 32'(err), 32'h1);

`ifdef FP32_MUL_ARB_STATS_EN
        #1;
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[32*i +: 32], 32'(gnt_exp[i]));
        chk("idle_cnt", idle_cnt, 32'(idle_exp));
`endif

        // Only reset clears err
        set_rst(1'b0);
        idle(2);
        set_rst(1'b1);
        idle(3);
        #1;
        chk("err_cleared", 32'(err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp32_mul_arbiter.md
# fp32_mul_arbiter

Round-robin arbiter that shares one pipelined FP32 multiplier among `NUM_REQ` requesters in the force pipeline. It accepts at most one operand pair per cycle and issues it to the multiplier through registered outputs. A tag shift register tracks in-flight operations, so each product is returned to the requester that issued it, with fixed latency and no reordering.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2 to 16.
- `MUL_LATENCY`, default 8: multiplier cycles from `mul_in_valid` to `mul_out_valid`, at least 1.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: per-requester operand valid.
- `req_ready`, out, NUM_REQ: one-hot grant; a handshake is `req_valid[i] & req_ready[i]`.
- `req_a`, in, 32*NUM_REQ: operand A of requester i at bits `[32i+31:32i]`.
- `req_b`, in, 32*NUM_REQ: operand B, packed the same way as `req_a`.
- `rsp_valid`, out, NUM_REQ: one-hot product valid; cannot be backpressured.
- `rsp_data`, out, 32: product, shared by all requesters and qualified by `rsp_valid`.
- `mul_a`, out, 32: registered operand A to the multiplier.
- `mul_b`, out, 32: registered operand B to the multiplier.
- `mul_in_valid`, out, 1: registered issue strobe to the multiplier.
- `mul_out_data`, in, 32: multiplier result.
- `mul_out_valid`, in, 1: multiplier result valid.
- `err`, out, 1: sticky flag for a tag/result mismatch.

## Operation
- **Grant:** combinational. The winner `g` is the lowest index at or after `rr_ptr`, with wrap, that has `req_valid` set. `req_ready = onehot(g)` if any `req_valid` is set, otherwise 0. `req_ready` depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **Round-robin pointer:** on a grant, `rr_ptr <= (g+1) mod NUM_REQ`. With no grant, `rr_ptr` is unchanged. Width is `$clog2(NUM_REQ)`.
- **Issue register:** on a grant, `mul_a <= req_a[g]`, `mul_b <= req_b[g]`, `mul_in_valid <= 1`. With no grant, `mul_in_valid <= 0` and `mul_a`/`mul_b` hold their values.
- **Tag pipe:** `MUL_LATENCY` stages of {valid, index}.
  - Stage 0 loads {`mul_in_valid`, index of the issue register}.
  - The pipe advances every cycle, so the last stage is aligned with `mul_out_valid`.
- **Response:**
  - Every cycle, `rsp_valid <= tag_last.valid ? onehot(tag_last.idx) : 0`.
  - When `tag_last.valid`, `rsp_data <= mul_out_data`; otherwise `rsp_data` holds.
- **Mismatch check:** if `mul_out_valid != tag_last.valid` while the drain counter is 0, set `err <= 1`. `err` clears only on reset.
- **Drain counter:** loaded with `MUL_LATENCY+1` on reset and decremented to 0. Mismatches are masked while it is nonzero, because the multiplier is not reset by this block and may still return old results.
- **Arithmetic:** this block does none. Operands and results pass through bit-exact, including NaN, Inf and denormals.

## Timing
- A handshake in cycle T gives `mul_in_valid` at T+1, `mul_out_valid` at T+1+MUL_LATENCY, and `rsp_valid` at T+2+MUL_LATENCY. Total latency is `MUL_LATENCY+2`.
- Throughput is 1 operation per cycle, shared across requesters. Each of k continuously active requesters gets exactly 1 of every k grants.
- Results return in issue order and are never dropped.
- Reset values:
  - `mul_a`, `mul_b`, `rsp_data`: 0.
  - `mul_in_valid`, `rsp_valid`, `err`: 0.
  - `rr_ptr`: 0; all tag valids: 0; drain counter: `MUL_LATENCY+1`.
  - `req_ready`: 0 while `rst_n` is low.
- Reset mid-operation discards all in-flight tags; no `rsp_valid` is produced for them.

## Configuration
- `FP32_MUL_ARB_STATS_EN` defined:
  - Adds output `grant_cnt` (32*NUM_REQ): a per-requester 32-bit handshake counter.
  - Adds output `idle_cnt` (32): counts cycles where `mul_in_valid` is 0.
  - Both counters wrap, and both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Single issue:** requester 2 issues `0x40400000 * 0x40000000`, MUL_LATENCY=8, bench multiplier model. Expect `rsp_valid = 4'b0100` and `rsp_data = 0x40C00000` exactly 10 cycles after the handshake; `err` = 0.
- **Round-robin fairness:** all 4 requesters hold `req_valid` for 12 cycles. Expect grants in order 0,1,2,3,0,… with 3 grants each, and `mul_in_valid` high for 12 consecutive cycles.
- **Response routing:** requesters 1 and 3 issue `0x3FC00000 * 0x3FC00000` and `0x40000000 * 0x40000000` back-to-back. Expect `rsp_valid` 4'b0010 with `0x40100000`, then 4'b1000 with `0x40800000` on the next cycle.
- **Sparse requests:** only requester 3 is valid, at cycles 0 and 5, with `rr_ptr` at 1. Both are granted immediately, and `rr_ptr` = 0 afterwards.
- **Reset mid-flight:** assert `rst_n` low 3 cycles after 4 issues, with the model still emitting the old results. Expect no `rsp_valid`, `err` = 0, and the next issue returning correctly.
- **Mismatch detection:** after drain, inject a spurious `mul_out_valid` pulse. Expect `err` = 1 on the next cycle and staying set until reset; with STATS_EN, `grant_cnt`/`idle_cnt` match the bench counts.
